ta_cap_ctrl: RTL and testbench

Pre/post-trigger capture controller sitting directly downstream of the ADC merge stage in the clk62 domain. It consumes the 56-bit merged sample words (four 14-bit samples per word) and their valid strobe, writes them continuously into an external circular capture RAM once armed, and on trigger writes a programmed number of post-trigger words. It then freezes and reports the record start address to the readout logic.

---
 rtl/ta_cap_ctrl_if.sv | 32 +++
 rtl/ta_cap_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ta_cap_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ta_cap_ctrl_if.sv
// Bundle of data/control inputs and capture-RAM/status outputs of the capture controller.
// The master side is the producer/controller of a record; the slave side is ta_cap_ctrl.
interface ta_cap_ctrl_if #(
    parameter int DATA_W = 56,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] din;
    logic              din_v;
    logic              arm;
    logic              trig;
    logic              abort;
    logic [ADDR_W-1:0] pre_len;
    logic [ADDR_W-1:0] post_len;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] start_addr;
    logic              trig_miss;

    modport master (
        output din, din_v, arm, trig, abort, pre_len, post_len,
        input  mem_we, mem_addr, mem_wdata, busy, done, start_addr, trig_miss
    );

    modport slave (
        input  din, din_v, arm, trig, abort, pre_len, post_len,
        output mem_we, mem_addr, mem_wdata, busy, done, start_addr, trig_miss
    );
endinterface

// File: rtl/ta_cap_ctrl.sv
// Pre/post-trigger capture controller: streams merged words into a circular RAM,
// stops after the programmed post-trigger count and reports the record start address.
module ta_cap_ctrl #(
    parameter int DATA_W = 56,
    parameter int ADDR_W = 10
) (
    input  logic         clk62,
    input  logic         rstn,
    ta_cap_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] wp_reg,         wp_next;
    logic [ADDR_W-1:0] pre_l_reg,      pre_l_next;
    logic [ADDR_W-1:0] post_l_reg,     post_l_next;
    logic [ADDR_W-1:0] fill_cnt_reg,   fill_cnt_next;
    logic [ADDR_W-1:0] post_cnt_reg,   post_cnt_next;
    logic [ADDR_W-1:0] trig_addr_reg,  trig_addr_next;
    logic [ADDR_W-1:0] start_addr_reg, start_addr_next;
    logic [ADDR_W-1:0] mem_addr_reg,   mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg,  mem_wdata_next;
    logic              mem_we_reg,     mem_we_next;
    logic              busy_reg,       busy_next;
    logic              done_reg,       done_next;
    logic              trig_miss_reg,  trig_miss_next;

    logic              write_en;
    logic              finish;
    logic [ADDR_W-1:0] finish_base;

    // Post length as it will be latched on arm: at least one word, clipped so
    // that pre + post never exceeds the ring size.
    logic [ADDR_W-1:0] post_min;
    logic [ADDR_W-1:0] post_room;
    logic [ADDR_W-1:0] post_clip;
    logic [ADDR_W:0]   len_sum;

    always_comb begin
        post_min  = (bus.post_len == '0) ? ADDR_W'(1) : bus.post_len;
        len_sum   = {1'b0, bus.pre_len} + {1'b0, post_min};
        post_room = ADDR_W'(0) - bus.pre_len;
        post_clip = (len_sum > DEPTH_W) ? post_room : post_min;
    end

    always_comb begin
        state_next      = state_reg;
        wp_next         = wp_reg;
        pre_l_next      = pre_l_reg;
        post_l_next     = post_l_reg;
        fill_cnt_next   = fill_cnt_reg;
        post_cnt_next   = post_cnt_reg;
        trig_addr_next  = trig_addr_reg;
        start_addr_next = start_addr_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_we_next     = 1'b0;
        trig_miss_next  = 1'b0;
        write_en        = 1'b0;
        finish          = 1'b0;
        finish_base     = trig_addr_reg;

        if (bus.abort) begin
            state_next = IDLE;
        end else if (bus.arm) begin
            pre_l_next    = bus.pre_len;
            post_l_next   = post_clip;
            wp_next       = '0;
            fill_cnt_next = '0;
            post_cnt_next = '0;
            state_next    = (bus.pre_len == '0) ? ARMED : FILL;
        end else begin
            unique case (state_reg)
                FILL: begin
                    trig_miss_next = bus.trig;
                    if (bus.din_v) begin
                        write_en      = 1'b1;
                        fill_cnt_next = fill_cnt_reg + ADDR_W'(1);
                        if (fill_cnt_next == pre_l_reg) begin
                            state_next = ARMED;
                        end
                    end
                end
                ARMED: begin
                    write_en = bus.din_v;
                    if (bus.trig) begin
                        trig_addr_next = wp_reg;
                        state_next     = POST;
                        // The word arriving with the trigger is the first post word.
                        if (bus.din_v) begin
                            post_cnt_next = ADDR_W'(1);
                            if (post_l_reg == ADDR_W'(1)) begin
                                finish      = 1'b1;
                                finish_base = wp_reg;
                            end
                        end
                    end
                end
                POST: begin
                    if (bus.din_v) begin
                        write_en      = 1'b1;
                        post_cnt_next = post_cnt_reg + ADDR_W'(1);
                        if (post_cnt_next == post_l_reg) begin
                            finish = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if (write_en) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = wp_reg;
            mem_wdata_next = bus.din;
            wp_next        = wp_reg + ADDR_W'(1);
        end

        if (finish) begin
            state_next      = DONE;
            start_addr_next = finish_base - pre_l_reg;
        end

        // Status flags decode the upcoming state so they line up with it.
        busy_next = (state_next == FILL) || (state_next == ARMED) || (state_next == POST);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk62 or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            wp_reg         <= '0;
            pre_l_reg      <= '0;
            post_l_reg     <= '0;
            fill_cnt_reg   <= '0;
            post_cnt_reg   <= '0;
            trig_addr_reg  <= '0;
            start_addr_reg <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            trig_miss_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wp_reg         <= wp_next;
            pre_l_reg      <= pre_l_next;
            post_l_reg     <= post_l_next;
            fill_cnt_reg   <= fill_cnt_next;
            post_cnt_reg   <= post_cnt_next;
            trig_addr_reg  <= trig_addr_next;
            start_addr_reg <= start_addr_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_we_reg     <= mem_we_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            trig_miss_reg  <= trig_miss_next;
        end
    end

    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.start_addr = start_addr_reg;
    assign bus.trig_miss  = trig_miss_reg;
endmodule

// File: tb/tb_ta_cap_ctrl.sv
// Self-checking bench for ta_cap_ctrl with a 16-word ring: a table of record
// scenarios with hand-computed results, then directed priority/abort/reset sequences.
module tb_ta_cap_ctrl;
    localparam int DATA_W = 56;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk62 = 1'b0;
    logic rstn  = 1'b1;

    ta_cap_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ta_cap_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk62 (clk62),
        .rstn  (rstn),
        .bus   (bus)
    );

    always #5 clk62 = ~clk62;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int pre;
        int post;
        int gap;
        int trig_at;
        int early_at;
        int exp_start;
        int exp_posts;
        int exp_lag;
        int exp_miss;
    } scen_t;

    scen_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk62);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input int id, input int k);
        return {8'hA5, 16'(id), 32'(k)};
    endfunction

    task automatic idle_inputs();
        bus.din      = '0;
        bus.din_v    = 1'b0;
        bus.arm      = 1'b0;
        bus.trig     = 1'b0;
        bus.abort    = 1'b0;
    endtask

    task automatic run_scen(input int id, input scen_t s);
        int  sent       = 0;
        int  writes     = 0;
        int  posts      = 0;
        int  misses     = 0;
        int  cyc        = 0;
        int  trig_step  = -1;
        int  done_step  = -1;
        bit  trig_done  = 1'b0;
        bit  this_trig;

        // Arm with a valid word in the same cycle: that word must be discarded.
        bus.arm      = 1'b1;
        bus.pre_len  = ADDR_W'(s.pre);
        bus.post_len = ADDR_W'(s.post);
        bus.din_v    = 1'b1;
        bus.din      = DATA_W'(56'hDEAD);
        step();
        bus.arm   = 1'b0;
        bus.din_v = 1'b0;
        check($sformatf("s%0d arm_we", id),   64'(bus.mem_we), 64'(0));
        check($sformatf("s%0d arm_busy", id), 64'(bus.busy),   64'(1));
        check($sformatf("s%0d arm_done", id), 64'(bus.done),   64'(0));

        while (!bus.done && cyc < 200) begin
            bus.din_v = ((cyc % s.gap) == 0);
            bus.din   = mk_data(id, sent);
            bus.trig  = 1'b0;
            this_trig = 1'b0;
            if (bus.din_v && !trig_done && sent == s.trig_at) begin
                bus.trig  = 1'b1;
                trig_done = 1'b1;
                this_trig = 1'b1;
            end else if (bus.din_v && sent == s.early_at) begin
                bus.trig = 1'b1;
            end
            if (bus.din_v) sent++;
            step();
            if (this_trig) trig_step = cyc;
            if (bus.trig_miss) misses++;
            if (bus.mem_we) begin
                check($sformatf("s%0d addr[%0d]", id, writes), 64'(bus.mem_addr), 64'(writes % DEPTH));
                check($sformatf("s%0d data[%0d]", id, writes), 64'(bus.mem_wdata), 64'(mk_data(id, writes)));
                if (writes >= s.trig_at) posts++;
                writes++;
            end
            if (bus.done) begin
                done_step = cyc;
                check($sformatf("s%0d busy_at_done", id), 64'(bus.busy), 64'(0));
            end else begin
                check($sformatf("s%0d busy[%0d]", id, cyc), 64'(bus.busy), 64'(1));
            end
            cyc++;
        end
        bus.trig  = 1'b0;
        bus.din_v = 1'b0;

        check($sformatf("s%0d done_reached", id), 64'(bus.done), 64'(1));
        check($sformatf("s%0d start_addr", id), 64'(bus.start_addr), 64'(s.exp_start));
        check($sformatf("s%0d post_writes", id), 64'(posts), 64'(s.exp_posts));
        check($sformatf("s%0d done_lag", id), 64'(done_step - trig_step), 64'(s.exp_lag));
        check($sformatf("s%0d trig_miss_cnt", id), 64'(misses), 64'(s.exp_miss));

        // DONE must ignore further words and keep its result.
        bus.din_v = 1'b1;
        repeat (3) begin
            step();
            check($sformatf("s%0d hold_we", id),    64'(bus.mem_we),     64'(0));
            check($sformatf("s%0d hold_done", id),  64'(bus.done),       64'(1));
            check($sformatf("s%0d hold_start", id), 64'(bus.start_addr), 64'(s.exp_start));
        end
        bus.din_v = 1'b0;
        $display("scenario %0d pre=%0d post=%0d gap=%0d trig_at=%0d -> start=%0d posts=%0d lag=%0d miss=%0d",
                 id, s.pre, s.post, s.gap, s.trig_at, bus.start_addr, posts, done_step - trig_step, misses);
    endtask

    // Arm with pre=1/post=8 and drive until two post words have been written.
    task automatic into_post();
        bus.arm = 1'b1; bus.pre_len = ADDR_W'(1); bus.post_len = ADDR_W'(8);
        step();
        bus.arm = 1'b0; bus.din_v = 1'b1;
        step();                              // fill word
        bus.trig = 1'b1;
        step();                              // trigger word
        bus.trig = 1'b0;
        step();                              // second post word
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pre post gap trig early start posts lag miss
        tbl[0] = '{3,   5,  1,  9,  -1,   6,   5,   4,   0};
        tbl[1] = '{4,   4,  1, 14,  -1,  10,   4,   3,   0};
        tbl[2] = '{10, 10,  1, 12,  -1,   2,   6,   5,   0};
        tbl[3] = '{8,   2,  1,  8,   3,   0,   2,   1,   1};
        tbl[4] = '{2,   1,  3,  5,  -1,   3,   1,   0,   0};
        tbl[5] = '{3,   2,  1, 20,  -1,   1,   2,   1,   0};
        tbl[6] = '{0,   0,  1,  0,  -1,   0,   1,   0,   0};
        tbl[7] = '{15,  3,  2, 17,  -1,   2,   1,   0,   0};

        idle_inputs();
        bus.pre_len  = '0;
        bus.post_len = '0;

        // Reset held with din_v toggling and an arm pulse.
        #3 rstn = 1'b0;
        bus.arm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.din_v = ~bus.din_v;
            step();
            check("rst_we",    64'(bus.mem_we),     64'(0));
            check("rst_busy",  64'(bus.busy),       64'(0));
            check("rst_done",  64'(bus.done),       64'(0));
            check("rst_start", 64'(bus.start_addr), 64'(0));
        end
        bus.arm = 1'b0;
        rstn = 1'b1;
        bus.din_v = 1'b1;
        repeat (3) begin
            step();
            check("idle_we",   64'(bus.mem_we), 64'(0));
            check("idle_busy", 64'(bus.busy),   64'(0));
        end
        bus.din_v = 1'b0;
        $display("reset sequence checked");

        for (int i = 0; i < 8; i++) run_scen(i, tbl[i]);

        // abort from DONE clears done
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_done_done", 64'(bus.done), 64'(0));
        check("abort_done_busy", 64'(bus.busy), 64'(0));
        $display("abort from DONE checked");

        // arm and abort together: abort wins
        bus.arm = 1'b1; bus.abort = 1'b1; bus.din_v = 1'b1; bus.pre_len = ADDR_W'(2);
        step();
        bus.arm = 1'b0; bus.abort = 1'b0;
        check("armabort_busy", 64'(bus.busy), 64'(0));
        step();
        check("armabort_we", 64'(bus.mem_we), 64'(0));
        bus.din_v = 1'b0;
        $display("arm+abort checked");

        // arm and trig together: record starts, trigger dropped silently
        bus.arm = 1'b1; bus.trig = 1'b1; bus.pre_len = ADDR_W'(4); bus.post_len = ADDR_W'(2);
        step();
        bus.arm = 1'b0; bus.trig = 1'b0;
        check("armtrig_busy", 64'(bus.busy),      64'(1));
        check("armtrig_miss", 64'(bus.trig_miss), 64'(0));
        bus.din_v = 1'b1;
        step();
        check("armtrig_addr0", 64'(bus.mem_addr), 64'(0));
        step();
        step();
        check("armtrig_not_done", 64'(bus.done), 64'(0));
        check("armtrig_busy2",    64'(bus.busy), 64'(1));
        bus.din_v = 1'b0;
        $display("arm+trig checked");

        // abort in POST with a word in the same cycle
        into_post();
        check("post_pre_abort_we", 64'(bus.mem_we), 64'(1));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_post_we",   64'(bus.mem_we), 64'(0));
        check("abort_post_busy", 64'(bus.busy),   64'(0));
        check("abort_post_done", 64'(bus.done),   64'(0));
        step();
        check("abort_post_we2",   64'(bus.mem_we), 64'(0));
        check("abort_post_done2", 64'(bus.done),   64'(0));
        bus.din_v = 1'b0;
        $display("abort in POST checked");

        // asynchronous reset in POST
        into_post();
        check("rstpost_pre_we",    64'(bus.mem_we),     64'(1));
        check("rstpost_pre_start", 64'(bus.start_addr), 64'(2));
        rstn = 1'b0;
        #1;
        check("rstpost_we",    64'(bus.mem_we),     64'(0));
        check("rstpost_busy",  64'(bus.busy),       64'(0));
        check("rstpost_done",  64'(bus.done),       64'(0));
        check("rstpost_start", 64'(bus.start_addr), 64'(0));
        check("rstpost_addr",  64'(bus.mem_addr),   64'(0));
        #3 rstn = 1'b1;
        step();
        check("rstpost_idle_we",   64'(bus.mem_we), 64'(0));
        check("rstpost_idle_busy", 64'(bus.busy),   64'(0));
        bus.din_v = 1'b0;
        $display("reset in POST checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
